// File: rtl/reveal_engine_pkg.sv
// Shared constants and FSM encoding for the reveal engine and the map generator.
package reveal_engine_pkg;

  localparam int MAP_WIDTH       = 8;
  localparam int MAP_HEIGHT      = 8;
  localparam int MAP_CELL_LENGTH = 4;

  // Cell value 0-8 is the neighbour mine count; all ones marks a mine.
  localparam logic [MAP_CELL_LENGTH-1:0] CELL_MINE = '1;

  typedef enum logic [1:0] {
    RE_IDLE,
    RE_CHECK,
    RE_SWEEP,
    RE_DONE
  } re_state_t;

endpackage

// File: rtl/reveal_engine_cell_neighbour_mask.sv
// Combinational mask of the in-bounds 8-neighbours of cell idx (no wrap at edges).
module cell_neighbour_mask #(
  parameter int W  = 8,
  parameter int H  = 8,
  parameter int N  = W * H,
  parameter int IW = $clog2(N)
) (
  input  logic [IW-1:0] idx,
  output logic [N-1:0]  mask
);

  always_comb begin
    int cx, cy, nx, ny;
    mask = '0;
    cx   = int'(idx) % W;
    cy   = int'(idx) / W;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx = cx + dx;
        ny = cy + dy;
        if ((dx != 0 || dy != 0) && nx >= 0 && nx < W && ny >= 0 && ny < H)
          mask[IW'(ny * W + nx)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reveal_engine.sv
// Reveal / flag / flood-fill engine feeding the VGA display; owns the shown and flag maps.
// Optional REVEAL_STATS_EN adds safe_left_o and win_o.
module reveal_engine
  import reveal_engine_pkg::*;
#(
  parameter int W = MAP_WIDTH,
  parameter int H = MAP_HEIGHT,
  parameter int L = MAP_CELL_LENGTH,
  parameter int N = W * H
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear_i,
  input  logic           reveal_req_i,
  input  logic           flag_req_i,
  input  logic [2:0]     x_pos_i,
  input  logic [2:0]     y_pos_i,
  input  logic [L*N-1:0] map_i,
  output logic [N-1:0]   map_shown_o,
  output logic [N-1:0]   map_flag_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           hit_mine_o
`ifdef REVEAL_STATS_EN
  ,
  output logic [6:0]     safe_left_o,
  output logic           win_o
`endif
);

  localparam int IW = $clog2(N);

  re_state_t       state, state_d;
  logic [IW-1:0]   idx, idx_d, sweep_idx, sweep_d, req_idx;
  logic            changed, changed_d, step_changed;
  logic [N-1:0]    shown, shown_d, flag, flag_d, mine_vec, nbr_mask;
  logic            hit, hit_d, done, done_d;
  logic            in_range, accept;
  logic [L-1:0]    cells [N];

  always_comb begin
    for (int j = 0; j < N; j++) begin
      cells[j]    = map_i[j*L +: L];
      mine_vec[j] = &map_i[j*L +: L];
    end
  end

  assign in_range = (int'(x_pos_i) < W) && (int'(y_pos_i) < H);
  assign req_idx  = IW'(int'(y_pos_i) * W + int'(x_pos_i));

  cell_neighbour_mask #(.W(W), .H(H), .N(N), .IW(IW)) u_nbr (
    .idx  (sweep_idx),
    .mask (nbr_mask)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d      = state;
    idx_d        = idx;
    sweep_d      = sweep_idx;
    changed_d    = changed;
    shown_d      = shown;
    flag_d       = flag;
    hit_d        = hit;
    done_d       = 1'b0;
    step_changed = 1'b0;
    if (clear_i) begin
      state_d   = RE_IDLE;
      sweep_d   = '0;
      changed_d = 1'b0;
      shown_d   = '0;
      flag_d    = '0;
      hit_d     = 1'b0;
    end else begin
      unique case (state)
        RE_IDLE: begin
          if (in_range && accept) begin
            if (reveal_req_i) begin
              idx_d   = req_idx;
              state_d = RE_CHECK;
            end else if (flag_req_i && !shown[req_idx]) begin
              flag_d[req_idx] = ~flag[req_idx];
            end
          end
        end
        RE_CHECK: begin
          state_d = RE_DONE;
          if (!flag[idx] && !shown[idx]) begin
            shown_d[idx] = 1'b1;
            if (mine_vec[idx]) begin
              hit_d = 1'b1;
            end else if (cells[idx] == '0) begin
              state_d   = RE_SWEEP;
              sweep_d   = '0;
              changed_d = 1'b0;
            end
          end
        end
        RE_SWEEP: begin
          if (shown[sweep_idx] && cells[sweep_idx] == '0)
            shown_d = shown | (nbr_mask & ~flag & ~mine_vec);
          step_changed = (shown_d != shown);
          if (sweep_idx == IW'(N - 1)) begin
            sweep_d   = '0;
            changed_d = 1'b0;
            if (!(changed || step_changed)) state_d = RE_DONE;
          end else begin
            sweep_d   = sweep_idx + IW'(1);
            changed_d = changed | step_changed;
          end
        end
        RE_DONE: begin
          state_d = RE_IDLE;
          done_d  = 1'b1;
        end
        default: state_d = RE_IDLE;
      endcase
    end
  end

  // The shown/flag maps are plain flop vectors, not a RAM, so they reset with everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RE_IDLE;
      idx       <= '0;
      sweep_idx <= '0;
      changed   <= 1'b0;
      shown     <= '0;
      flag      <= '0;
      hit       <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state     <= state_d;
      idx       <= idx_d;
      sweep_idx <= sweep_d;
      changed   <= changed_d;
      shown     <= shown_d;
      flag      <= flag_d;
      hit       <= hit_d;
      done      <= done_d;
    end
  end

  assign map_shown_o = shown;
  assign map_flag_o  = flag;
  assign hit_mine_o  = hit;
  assign done_o      = done;

`ifdef REVEAL_STATS_EN
  logic          counting, win;
  logic [IW-1:0] cnt_idx;
  logic [6:0]    tally, tally_d, safe_left, newly;

  always_comb begin
    newly = '0;
    for (int j = 0; j < N; j++)
      newly = newly + 7'(shown_d[j] & ~shown[j] & ~mine_vec[j]);
    tally_d = tally + 7'(~mine_vec[cnt_idx]);
  end

  // After reset or clear, one pass over the map counts the safe cells before requests are taken.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      counting  <= 1'b1;
      cnt_idx   <= '0;
      tally     <= '0;
      safe_left <= '0;
      win       <= 1'b0;
    end else if (counting) begin
      tally   <= tally_d;
      cnt_idx <= cnt_idx + IW'(1);
      if (cnt_idx == IW'(N - 1)) begin
        counting  <= 1'b0;
        safe_left <= tally_d;
      end
    end else begin
      safe_left <= safe_left - newly;
      if (newly != '0 && safe_left == newly && !hit_d) win <= 1'b1;
    end
  end

  assign safe_left_o = safe_left;
  assign win_o       = win;
  assign busy_o      = (state != RE_IDLE) || counting;
  assign accept      = !counting;
`else
  assign busy_o      = (state != RE_IDLE);
  assign accept      = 1'b1;
`endif

endmodule

// File: tb/tb_reveal_engine.sv
// Self-checking bench for reveal_engine: table-driven single-cell ops plus flood-fill and clear sequences.
module tb_reveal_engine;
  import reveal_engine_pkg::*;

  localparam int W      = 8;
  localparam int H      = 8;
  localparam int L      = 4;
  localparam int N      = W * H;
  localparam int BUDGET = 2 + N * N + 8;

  typedef enum {OP_CLEAR, OP_REVEAL, OP_FLAG, OP_BOTH} op_e;
  typedef struct {
    op_e         op;
    int          x;
    int          y;
    logic [63:0] shown;
    logic [63:0] flag;
    logic        hit;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst, clear_i, reveal_req_i, flag_req_i;
  logic [2:0]     x_pos_i, y_pos_i;
  logic [L*N-1:0] map_i;
  logic [N-1:0]   map_shown_o, map_flag_o;
  logic           busy_o, done_o, hit_mine_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reveal_engine #(.W(W), .H(H), .L(L)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clear_i),
    .reveal_req_i (reveal_req_i),
    .flag_req_i   (flag_req_i),
    .x_pos_i      (x_pos_i),
    .y_pos_i      (y_pos_i),
    .map_i        (map_i),
    .map_shown_o  (map_shown_o),
    .map_flag_o   (map_flag_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .hit_mine_o   (hit_mine_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill_map(input logic [3:0] v);
    for (int j = 0; j < N; j++) map_i[j*L +: L] = v;
  endtask

  task automatic set_cell(input int x, input int y, input logic [3:0] v);
    map_i[(y*W + x)*L +: L] = v;
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
  endtask

  task automatic do_flag(input int x, input int y);
    x_pos_i    = 3'(x);
    y_pos_i    = 3'(y);
    flag_req_i = 1'b1;
    step();
    flag_req_i = 1'b0;
    step();
  endtask

  // Returns cycles from the sampling edge until done_o is seen (BUDGET on timeout).
  task automatic do_reveal(input int x, input int y, input logic with_flag, output int lat);
    x_pos_i      = 3'(x);
    y_pos_i      = 3'(y);
    reveal_req_i = 1'b1;
    flag_req_i   = with_flag;
    step();
    reveal_req_i = 1'b0;
    flag_req_i   = 1'b0;
    lat = 0;
    while (!done_o && lat < BUDGET) begin
      step();
      lat++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [12];
    logic [63:0] s1, s2, s3, s4, s5, s6, full;
    int          lat, n;

    s1   = 64'd1 << 42;
    s2   = s1 | (64'd1 << 11);
    s3   = s2 | (64'd1 << 5);
    s4   = s3 | 64'd1;
    s5   = s4 | (64'd1 << 36);
    s6   = s5 | (64'd1 << 63);
    full = ~(64'd1 << 63);

    vecs[0]  = '{OP_CLEAR,  0, 0, 64'd0, 64'd0,          1'b0};
    vecs[1]  = '{OP_REVEAL, 2, 5, s1,    64'd0,          1'b0};
    vecs[2]  = '{OP_FLAG,   2, 5, s1,    64'd0,          1'b0};
    vecs[3]  = '{OP_FLAG,   3, 1, s1,    64'd1 << 11,    1'b0};
    vecs[4]  = '{OP_REVEAL, 3, 1, s1,    64'd1 << 11,    1'b0};
    vecs[5]  = '{OP_FLAG,   3, 1, s1,    64'd0,          1'b0};
    vecs[6]  = '{OP_REVEAL, 3, 1, s2,    64'd0,          1'b0};
    vecs[7]  = '{OP_BOTH,   5, 0, s3,    64'd0,          1'b0};
    vecs[8]  = '{OP_REVEAL, 0, 0, s4,    64'd0,          1'b0};
    vecs[9]  = '{OP_REVEAL, 4, 4, s5,    64'd0,          1'b1};
    vecs[10] = '{OP_REVEAL, 7, 7, s6,    64'd0,          1'b1};
    vecs[11] = '{OP_CLEAR,  0, 0, 64'd0, 64'd0,          1'b0};

    rst = 1'b1; clear_i = 1'b0; reveal_req_i = 1'b0; flag_req_i = 1'b0;
    x_pos_i = '0; y_pos_i = '0;
    fill_map(4'd1);
    set_cell(2, 5, 4'd3);
    set_cell(4, 4, CELL_MINE);
    set_cell(0, 0, 4'd2);

    // Reset
    step();
    step();
    rst = 1'b0;
    check("reset_shown", map_shown_o, 64'd0);
    check("reset_flag",  map_flag_o,  64'd0);
    check("reset_busy",  busy_o,      1'b0);
    check("reset_done",  done_o,      1'b0);
    check("reset_hit",   hit_mine_o,  1'b0);

    // Exact latency of a non-zero reveal at (2,5)
    x_pos_i = 3'd2; y_pos_i = 3'd5; reveal_req_i = 1'b1;
    step();
    reveal_req_i = 1'b0;
    check("lat_e0_busy",  busy_o,      1'b1);
    check("lat_e0_shown", map_shown_o, 64'd0);
    step();
    check("lat_e1_shown", map_shown_o, s1);
    check("lat_e1_done",  done_o,      1'b0);
    step();
    check("lat_e2_done",  done_o,      1'b1);
    check("lat_e2_busy",  busy_o,      1'b0);
    step();
    check("lat_e3_done",  done_o,      1'b0);

    // Table of single-cell operations on the non-zero map
    for (int i = 0; i < 12; i++) begin
      case (vecs[i].op)
        OP_CLEAR: begin
          pulse_clear();
          check($sformatf("v%0d_done", i), done_o, 1'b0);
        end
        OP_FLAG: do_flag(vecs[i].x, vecs[i].y);
        default: begin
          do_reveal(vecs[i].x, vecs[i].y, vecs[i].op == OP_BOTH, lat);
          check($sformatf("v%0d_latency", i), lat, 2);
          step();
        end
      endcase
      check($sformatf("v%0d_shown", i), map_shown_o, vecs[i].shown);
      check($sformatf("v%0d_flag", i),  map_flag_o,  vecs[i].flag);
      check($sformatf("v%0d_hit", i),   hit_mine_o,  vecs[i].hit);
      check($sformatf("v%0d_busy", i),  busy_o,      1'b0);
    end

    // Flood fill: all-zero map with a single mine at (7,7)
    fill_map(4'd0);
    set_cell(7, 7, CELL_MINE);
    pulse_clear();
    do_reveal(0, 0, 1'b0, lat);
    check("flood_done",    done_o,      1'b1);
    check("flood_latency", lat,         2 + 2 * N);
    check("flood_shown",   map_shown_o, full);
    check("flood_hit",     hit_mine_o,  1'b0);
    step();

    // Flagged (1,0) blocks the flood; flag on a shown cell is not toggled
    pulse_clear();
    do_flag(1, 0);
    do_reveal(0, 0, 1'b0, lat);
    check("fflood_done",   done_o,            1'b1);
    check("fflood_passes", (lat - 2) % N,     0);
    check("fflood_shown",  map_shown_o,       full & ~(64'd1 << 1));
    check("fflood_flag",   map_flag_o,        64'd1 << 1);
    step();
    do_flag(0, 0);
    check("flag_on_shown", map_flag_o,        64'd1 << 1);

    // A reveal request during SWEEP is ignored
    pulse_clear();
    x_pos_i = 3'd0; y_pos_i = 3'd0; reveal_req_i = 1'b1;
    step();
    reveal_req_i = 1'b0;
    repeat (10) step();
    check("sweep_busy", busy_o, 1'b1);
    x_pos_i = 3'd5; y_pos_i = 3'd5; reveal_req_i = 1'b1;
    step();
    reveal_req_i = 1'b0;
    lat = 11;
    while (!done_o && lat < BUDGET) begin
      step();
      lat++;
    end
    check("ign_done",    done_o,      1'b1);
    check("ign_latency", lat,         2 + 2 * N);
    check("ign_shown",   map_shown_o, full);
    step();
    n = 0;
    repeat (10) begin
      if (done_o) n++;
      step();
    end
    check("ign_no_second_done", n,      0);
    check("ign_idle",           busy_o, 1'b0);

    // clear_i mid-SWEEP aborts the sweep without a done pulse
    pulse_clear();
    x_pos_i = 3'd0; y_pos_i = 3'd0; reveal_req_i = 1'b1;
    step();
    reveal_req_i = 1'b0;
    repeat (20) step();
    check("abort_pre_busy", busy_o, 1'b1);
    pulse_clear();
    check("abort_busy",  busy_o,      1'b0);
    check("abort_shown", map_shown_o, 64'd0);
    check("abort_flag",  map_flag_o,  64'd0);
    check("abort_done",  done_o,      1'b0);
    n = 0;
    repeat (2 * N + 10) begin
      if (done_o || busy_o) n++;
      step();
    end
    check("abort_quiet", n,           0);
    check("abort_final", map_shown_o, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reveal_engine.md
Name: reveal_engine

Overview:
- Game-logic stage directly upstream of the VGA display top.
- Owns and produces `map_shown` and `map_flag`; the display consumes both.
- Handles single-cell reveal and flag toggles, and runs flood-fill expansion from zero-count cells.
- The static game map `map_i` comes from the map generator and is read-only here.

Parameters:
- `W`, default `MAP_WIDTH` (8): columns.
- `H`, default `MAP_HEIGHT` (8): rows.
- `L`, default `MAP_CELL_LENGTH` (4): bits per cell.
- `N`, default `W*H` (64): cell count, derived.

Ports:
- `clk`  in  1  system clock, 100 MHz
- `rst`  in  1  synchronous reset, active-high
- `clear_i`  in  1  new-game pulse; clears shown and flag maps
- `reveal_req_i`  in  1  reveal request pulse
- `flag_req_i`  in  1  flag-toggle request pulse
- `x_pos_i`  in  3  target column
- `y_pos_i`  in  3  target row
- `map_i`  in  L*N  cell values; cell idx = y*W+x occupies bits `[idx*L +: L]`
- `map_shown_o`  out  N  bit idx = 1 means revealed
- `map_flag_o`  out  N  bit idx = 1 means flagged
- `busy_o`  out  1  high in any state except IDLE
- `done_o`  out  1  one-cycle pulse when a request completes
- `hit_mine_o`  out  1  sticky; a mine was revealed

Behaviour:
- Reset (`rst` = 1 at a clk edge):
  - All outputs go to 0.
  - State goes to IDLE; internal pass index and change flag are cleared.
- Cell encoding: 0–8 is the neighbour mine count; `CELL_MINE` (all ones) is a mine.
- FSM states: IDLE, CHECK, SWEEP, DONE.
- IDLE:
  - `reveal_req_i` latches x,y, then goes to CHECK.
  - Otherwise `flag_req_i` toggles `flag[idx]`, but only if `shown[idx]` = 0; no state change, no `done_o`.
  - If both requests arrive in the same cycle, reveal wins and the flag request is dropped.
- Requests arriving in any non-IDLE state are ignored, not queued.
- CHECK:
  - If `flag[idx]` or `shown[idx]` is set: no change, go to DONE.
  - Otherwise set `shown[idx]`.
  - If the cell is a mine: set `hit_mine_o`, go to DONE.
  - If the value is nonzero: go to DONE.
  - If the value is 0: go to SWEEP with index = 0 and `changed` = 0.
- SWEEP (one cell per cycle, index i from 0 to N-1):
  - If `shown[i]` is set and `value[i]` = 0, set `shown` for each in-bounds neighbour that is not flagged and not a mine.
  - Set `changed` if any bit transitioned.
  - Neighbours are the 8 surrounding cells clipped at edges. There is no wrap: x=0 has no left column, x=W-1 has no right column, and likewise for y.
  - At i = N-1: if `changed` (including this cycle's change), restart at i=0 with `changed` cleared; else go to DONE.
- DONE: `done_o` = 1 for exactly one cycle, then IDLE.
- Latency, measured from the edge that samples `reveal_req_i`:
  - Non-zero cell: `shown` updates at +1 edge, `done_o` is high during the cycle after the +2 edge.
  - Zero cell: `done_o` comes after k full passes (k ≥ 1), i.e. 2 + k*N cycles.
  - Worst case k ≤ N.
- `clear_i`:
  - Highest priority over everything except `rst`; honoured in any state.
  - Next edge: `shown`, `flag` and `hit_mine_o` go to 0, state goes to IDLE, `done_o` = 0.
  - A sweep in progress is aborted.
- Outputs are registered; `map_shown_o`/`map_flag_o` change only on clk edges.
- `x_pos_i`/`y_pos_i` ≥ W/H: the request is ignored; the FSM stays in IDLE.

Optional Feature:
- Macro: `REVEAL_STATS_EN`.
- When defined, adds two outputs:
  - `safe_left_o [6:0]`: count of non-mine cells not yet shown. Recomputed incrementally: decrement on each 0→1 `shown` transition of a non-mine cell; reload on `clear_i`/`rst` by a one-pass count over N cycles while `busy_o` = 1.
  - `win_o`: sticky; set when `safe_left_o` reaches 0 with `hit_mine_o` = 0.
- When not defined, neither port exists and no counter logic is built.

Decomposition:
- Shared constants go in `parameter.v`: `MAP_WIDTH`, `MAP_HEIGHT`, `MAP_CELL_LENGTH`, `CELL_MINE`, state encodings `RE_IDLE`/`RE_CHECK`/`RE_SWEEP`/`RE_DONE`.
- One sub-module: `cell_neighbour_mask`. Combinational; takes index i and outputs an N-bit mask of in-bounds neighbours. It is reused by the map generator.

Test Plan:
- Reset: assert `rst` for 2 cycles → all outputs 0, `busy_o` = 0.
- Reveal a cell of value 3 at (2,5): `shown[42]` = 1 at +1 edge, `done_o` one cycle, no other bits change.
- All-zero map except a mine at (7,7):
  - Reveal (0,0) → all 63 safe cells shown, `shown[63]` = 0.
  - `done_o` within 2+N*passes cycles; `hit_mine_o` = 0.
- Flag (1,0) then reveal (0,0) on a zero region: (1,0) stays hidden and flagged. A flag request on a shown cell produces no toggle.
- Reveal a mine at (4,4): `shown[36]` = 1, `hit_mine_o` = 1 stays through later requests. Then `clear_i` → `hit_mine_o` = 0, maps 0.
- Assert `clear_i` mid-SWEEP: next edge IDLE, maps 0, no `done_o` pulse. A `reveal_req_i` during SWEEP is ignored.
